// File: rtl/miner_job_ctrl.sv
// Host command sequencer: parses LOAD/READ/START/STATUS byte commands and masters the register-file byte port.
// Optional inter-byte command timeout is built only when CMD_TIMEOUT_EN is defined.
module miner_job_ctrl #(
  parameter int unsigned NUM_CFG_BYTES  = 76,
  parameter int unsigned CFG_BASE       = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [6:0] reg_num,
  output logic       reg_wr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  input  logic       core_busy,
  output logic       core_start
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RD_ADDR, RD_DATA, STAT, START, RESP
  } state_t;

  localparam logic [7:0] OP_LOAD   = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_START  = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h04;
  localparam logic [7:0] REPLY_OK  = 8'hA5;
  localparam logic [7:0] REPLY_ERR = 8'hEE;
  localparam logic [7:0] REPLY_TMO = 8'hE7;
  localparam logic [6:0] BASE7     = 7'(CFG_BASE);
  localparam logic [6:0] LAST_IDX  = 7'(NUM_CFG_BYTES - 1);
  localparam logic [6:0] STAT_LAST = 7'd4;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t     state;
  logic [6:0] byte_cnt;
  logic       busy_at_op;
  logic       stat_phase;
  logic       rx_hs;
  logic       timed_out;

  assign rx_hs = rx_valid & rx_ready;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_cnt;
  logic          waiting;

  assign waiting = (state == LOAD) || (state == RD_ADDR);
  // Fires one cycle early so the registered E7 reply appears on the TIMEOUT_CYCLES-th idle cycle.
  assign timed_out = waiting && !rx_hs && (idle_cnt == TW'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (reset || rx_hs || !waiting) idle_cnt <= '0;
    else if (!timed_out)            idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rx_ready   <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      reg_num    <= '0;
      reg_wr     <= 1'b0;
      reg_wdata  <= '0;
      core_start <= 1'b0;
      byte_cnt   <= '0;
      busy_at_op <= 1'b0;
      stat_phase <= 1'b0;
    end else begin
      reg_wr     <= 1'b0;
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          if (rx_hs) begin
            case (rx_data)
              OP_LOAD: begin
                state      <= LOAD;
                byte_cnt   <= '0;
                busy_at_op <= core_busy;
              end
              OP_READ:  state <= RD_ADDR;
              OP_START: begin
                state    <= START;
                rx_ready <= 1'b0;
              end
              OP_STATUS: begin
                state      <= STAT;
                reg_num    <= '0;
                stat_phase <= 1'b0;
                rx_ready   <= 1'b0;
              end
              default: begin
                tx_data  <= REPLY_ERR;
                tx_valid <= 1'b1;
                state    <= RESP;
                rx_ready <= 1'b0;
              end
            endcase
          end
        end
        LOAD: begin
          if (rx_hs) begin
            if (!busy_at_op) begin
              reg_wr    <= 1'b1;
              reg_num   <= BASE7 + byte_cnt;
              reg_wdata <= rx_data;
            end
            if (byte_cnt == LAST_IDX) begin
              tx_data  <= busy_at_op ? REPLY_ERR : REPLY_OK;
              tx_valid <= 1'b1;
              state    <= RESP;
              rx_ready <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + 7'd1;
            end
          end else if (timed_out) begin
            tx_data  <= REPLY_TMO;
            tx_valid <= 1'b1;
            state    <= RESP;
            rx_ready <= 1'b0;
          end
        end
        RD_ADDR: begin
          if (rx_hs) begin
            reg_num  <= rx_data[6:0];
            state    <= RD_DATA;
            rx_ready <= 1'b0;
          end else if (timed_out) begin
            tx_data  <= REPLY_TMO;
            tx_valid <= 1'b1;
            state    <= RESP;
            rx_ready <= 1'b0;
          end
        end
        RD_DATA: begin
          tx_data  <= reg_rdata;
          tx_valid <= 1'b1;
          state    <= RESP;
        end
        STAT: begin
          // Each address gets a settle cycle then a sample cycle; next address only after handshake.
          if (tx_valid) begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              if (reg_num == STAT_LAST) begin
                state    <= IDLE;
                rx_ready <= 1'b1;
              end else begin
                reg_num    <= reg_num + 7'd1;
                stat_phase <= 1'b0;
              end
            end
          end else if (!stat_phase) begin
            stat_phase <= 1'b1;
          end else begin
            tx_data  <= reg_rdata;
            tx_valid <= 1'b1;
          end
        end
        START: begin
          core_start <= !core_busy;
          tx_data    <= core_busy ? REPLY_ERR : REPLY_OK;
          tx_valid   <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
            rx_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miner_job_ctrl.sv
// Directed/randomised bench for miner_job_ctrl against a byte-level command model and a small register file.
module tb_miner_job_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [6:0] reg_num;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       core_busy;
  logic       core_start;

  miner_job_ctrl #(.NUM_CFG_BYTES(76), .CFG_BASE(5), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .reg_num(reg_num), .reg_wr(reg_wr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .core_busy(core_busy), .core_start(core_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file: addresses 0..4 are the status snapshot, the rest are plain bytes.
  logic [7:0] stat_bytes [5];
  logic [7:0] mem [128];
  assign reg_rdata = (reg_num < 7'd5) ? stat_bytes[reg_num] : mem[reg_num];

  typedef struct {
    int unsigned cyc;
    logic [6:0]  addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         wr_q[$];
  logic [7:0]  tx_q[$];
  int unsigned start_q[$];
  int unsigned cyc = 0;
  int unsigned overlap = 0;
  int unsigned last_rx_cyc = 0;
  int unsigned tx_rise_cyc = 0;
  logic        prev_txv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reg_wr) begin
      wr_q.push_back('{cyc, reg_num, reg_wdata});
      mem[reg_num] = reg_wdata;
    end
    if (core_start) start_q.push_back(cyc);
    if (reg_wr && core_start) overlap++;
    if (!reset && rx_valid && rx_ready) last_rx_cyc = cyc;
    if (!reset && tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (tx_valid && !prev_txv) tx_rise_cyc = cyc;
    prev_txv = tx_valid;
  end

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned tx_rd = 0;
  logic [7:0]  ld_model [76];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    logic ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    if (!ok) chk({tag, "_rx_accept"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_tx(input int unsigned n, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (tx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    #1;
    if (!ok) chk({tag, "_tx_timeout"}, 32'(tx_q.size()), 32'(n));
  endtask

  task automatic get_reply(input logic [7:0] exp, input string tag);
    wait_tx(tx_rd + 1, tag);
    if (tx_q.size() > tx_rd) begin
      chk(tag, 32'(tx_q[tx_rd]), 32'(exp));
      tx_rd++;
    end
  endtask

  // mode 0: bytes 0x00..0x4B; mode 1: random with byte 11 (address 16) forced to 0x3C
  task automatic do_load(input logic busy, input int mode, input string tag);
    logic [7:0]  b [76];
    int unsigned base;
    base = wr_q.size();
    for (int k = 0; k < 76; k++) b[k] = (mode == 0) ? 8'(k) : 8'($urandom_range(0, 255));
    if (mode != 0) b[11] = 8'h3C;
    core_busy = busy;
    send(8'h01, tag);
    core_busy = 1'b0;
    for (int k = 0; k < 76; k++) send(b[k], tag);
    get_reply(busy ? 8'hEE : 8'hA5, {tag, "_reply"});
    chk({tag, "_wr_count"}, 32'(wr_q.size() - base), busy ? 32'd0 : 32'd76);
    if (!busy && wr_q.size() >= base + 76) begin
      for (int k = 0; k < 76; k++) begin
        chk($sformatf("%s_wr%0d", tag, k),
            {8'(wr_q[base + k].cyc - wr_q[base].cyc), 1'b0, wr_q[base + k].addr, wr_q[base + k].data},
            {8'(k), 1'b0, 7'(5 + k), b[k]});
        ld_model[k] = b[k];
      end
    end
  endtask

  task automatic do_read(input logic [7:0] a, input string tag);
    logic [6:0] addr;
    logic [7:0] exp;
    addr = a[6:0];
    exp = (addr < 7'd5) ? stat_bytes[addr] : ld_model[addr - 7'd5];
    send(8'h02, tag);
    send(a, tag);
    get_reply(exp, tag);
    chk({tag, "_latency"}, tx_rise_cyc - last_rx_cyc, 32'd2);
  endtask

  task automatic do_status(input logic stall, input string tag);
    logic [7:0] exp [5];
    for (int i = 0; i < 5; i++) exp[i] = stat_bytes[i];
    tx_ready = 1'b1;
    send(8'h04, tag);
    if (stall) begin
      wait_tx(tx_rd + 2, tag);
      tx_ready = 1'b0;
      tick(10);
      tx_ready = 1'b1;
    end
    wait_tx(tx_rd + 5, tag);
    tick(20);
    chk({tag, "_count"}, 32'(tx_q.size() - tx_rd), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (tx_q.size() > tx_rd) begin
        chk($sformatf("%s_b%0d", tag, i), 32'(tx_q[tx_rd]), 32'(exp[i]));
        tx_rd++;
      end
    end
  endtask

  initial begin
    int unsigned s;
    int unsigned w;
    logic [7:0]  op;
    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = '0;
    tx_ready  = 1'b1;
    core_busy = 1'b0;
    stat_bytes[0] = 8'h03; stat_bytes[1] = 8'hDE; stat_bytes[2] = 8'hAD;
    stat_bytes[3] = 8'hBE; stat_bytes[4] = 8'hEF;
    tick(3);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_reg_num", 32'(reg_num), 32'd0);
    chk("rst_reg_wr", 32'(reg_wr), 32'd0);
    chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    reset = 1'b0;
    tick(2);
    chk("idle_rx_ready", 32'(rx_ready), 32'd1);

    do_load(1'b0, 0, "load_seq");
    do_load(1'b0, 1, "load_rand");
    do_load(1'b1, 1, "load_busy");

    do_read(8'h10, "read_10");
    chk("read_10_val", 32'(ld_model[11]), 32'h3C);
    do_read(8'h83, "read_bit7");
    for (int i = 0; i < 5; i++) do_read(8'($urandom_range(0, 80)), $sformatf("read_rand%0d", i));

    do_status(1'b1, "status_stall");
    for (int i = 0; i < 5; i++) stat_bytes[i] = 8'($urandom_range(0, 255));
    do_status(1'b0, "status_rand");

    s = start_q.size();
    core_busy = 1'b0;
    send(8'h03, "start_idle");
    get_reply(8'hA5, "start_idle_reply");
    tick(5);
    chk("start_idle_pulses", 32'(start_q.size() - s), 32'd1);
    s = start_q.size();
    core_busy = 1'b1;
    send(8'h03, "start_busy");
    get_reply(8'hEE, "start_busy_reply");
    tick(5);
    core_busy = 1'b0;
    chk("start_busy_pulses", 32'(start_q.size() - s), 32'd0);

    s = start_q.size();
    w = wr_q.size();
    send(8'h7F, "bad_7f");
    get_reply(8'hEE, "bad_7f_reply");
    send(8'h00, "bad_00");
    get_reply(8'hEE, "bad_00_reply");
    for (int i = 0; i < 3; i++) begin
      op = 8'($urandom_range(5, 255));
      send(op, "bad_rand");
      get_reply(8'hEE, $sformatf("bad_rand_%0h", op));
    end
    chk("bad_no_side_effects", 32'((start_q.size() - s) + (wr_q.size() - w)), 32'd0);

    w = wr_q.size();
    send(8'h01, "load_rst");
    for (int k = 0; k <= 20; k++) send(8'($urandom_range(0, 255)), "load_rst");
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(30);
    chk("load_rst_wr_count", 32'(wr_q.size() - w), 32'd21);
    chk("load_rst_last_addr", 32'(wr_q[wr_q.size() - 1].addr), 32'd25);
    chk("load_rst_tx_idle", 32'(tx_valid), 32'd0);
    do_load(1'b0, 1, "load_after_rst");

`ifdef CMD_TIMEOUT_EN
    w = wr_q.size();
    send(8'h01, "tmo_load");
    for (int k = 0; k <= 10; k++) send(8'($urandom_range(0, 255)), "tmo_load");
    get_reply(8'hE7, "tmo_load_reply");
    chk("tmo_load_latency", tx_rise_cyc - last_rx_cyc, 32'd100);
    chk("tmo_load_wr_count", 32'(wr_q.size() - w), 32'd11);
    send(8'h02, "tmo_read");
    get_reply(8'hE7, "tmo_read_reply");
    do_read(8'h10, "read_after_tmo");
`endif

    chk("no_wr_start_overlap", 32'(overlap), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
